// File: rtl/clk_en_gen.sv
// clk_en_gen: NUM_CH programmable divided clocks with ticks and lock, all in the refclk domain.
// Define CLK_EN_GEN_SYNC_EN to add sync_req, which restarts every channel's period on one edge.
module clk_en_gen #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_DIV  = 30,
    parameter int DEFAULT_HIGH = 15,
    parameter int LOCK_CYCLES  = 16
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic [NUM_CH*CNT_W-1:0] cfg_div,
    input  logic [NUM_CH*CNT_W-1:0] cfg_high,
    input  logic                    cfg_load,
`ifdef CLK_EN_GEN_SYNC_EN
    input  logic                    sync_req,
`endif
    output logic                    cfg_busy,
    output logic [NUM_CH-1:0]       outclk,
    output logic [NUM_CH-1:0]       tick,
    output logic                    locked
);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic [CNT_W-1:0] div_q [NUM_CH];
    logic [CNT_W-1:0] div_d [NUM_CH];
    logic [CNT_W-1:0] high_q [NUM_CH];
    logic [CNT_W-1:0] high_d [NUM_CH];
    logic [CNT_W-1:0] sdiv_q [NUM_CH];
    logic [CNT_W-1:0] sdiv_d [NUM_CH];
    logic [CNT_W-1:0] shigh_q [NUM_CH];
    logic [CNT_W-1:0] shigh_d [NUM_CH];
    logic [CNT_W-1:0] cdiv [NUM_CH];
    logic [CNT_W-1:0] chigh [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d, apply, outclk_q, outclk_d, tick_q, tick_d;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
    logic              busy_q, locked_q, locked_d, sync;

    always_comb begin
`ifdef CLK_EN_GEN_SYNC_EN
        sync = sync_req;
`else
        sync = 1'b0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            cdiv[i]    = cfg_div[i*CNT_W +: CNT_W] < CNT_W'(2) ? CNT_W'(2) : cfg_div[i*CNT_W +: CNT_W];
            chigh[i]   = cfg_high[i*CNT_W +: CNT_W] == '0 ? CNT_W'(1) :
                         cfg_high[i*CNT_W +: CNT_W] >= cdiv[i] ? cdiv[i] - CNT_W'(1) :
                         cfg_high[i*CNT_W +: CNT_W];
            // a period ends at the wrap (or a sync); that is the only point new settings take effect
            apply[i]   = (cnt_q[i] == div_q[i] - CNT_W'(1)) | sync;
            cnt_d[i]   = apply[i] ? '0 : cnt_q[i] + CNT_W'(1);
            div_d[i]   = !apply[i] ? div_q[i] : cfg_load ? cdiv[i] : pend_q[i] ? sdiv_q[i] : div_q[i];
            high_d[i]  = !apply[i] ? high_q[i] : cfg_load ? chigh[i] : pend_q[i] ? shigh_q[i] : high_q[i];
            sdiv_d[i]  = cfg_load ? cdiv[i] : sdiv_q[i];
            shigh_d[i] = cfg_load ? chigh[i] : shigh_q[i];
            pend_d[i]  = !apply[i] & (cfg_load | pend_q[i]);
            outclk_d[i] = cnt_q[i] < high_q[i];
            tick_d[i]   = cnt_q[i] == '0;
        end
        lock_cnt_d = lock_cnt_q == LW'(LOCK_CYCLES) ? lock_cnt_q : lock_cnt_q + LW'(1);
        locked_d   = (lock_cnt_q == LW'(LOCK_CYCLES)) & ~|pend_q & ~cfg_load;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= '0;
                div_q[i]   <= CNT_W'(DEFAULT_DIV);
                high_q[i]  <= CNT_W'(DEFAULT_HIGH);
                sdiv_q[i]  <= CNT_W'(DEFAULT_DIV);
                shigh_q[i] <= CNT_W'(DEFAULT_HIGH);
            end
            pend_q     <= '0;
            outclk_q   <= '0;
            tick_q     <= '0;
            busy_q     <= 1'b0;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                div_q[i]   <= div_d[i];
                high_q[i]  <= high_d[i];
                sdiv_q[i]  <= sdiv_d[i];
                shigh_q[i] <= shigh_d[i];
            end
            pend_q     <= pend_d;
            outclk_q   <= outclk_d;
            tick_q     <= tick_d;
            busy_q     <= |pend_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign cfg_busy = busy_q;
    assign outclk   = outclk_q;
    assign tick     = tick_q;
    assign locked   = locked_q;
endmodule
